// File: rtl/alu_types.sv
// Command encoding shared by the address ALU and its users.
package alu_types;

  typedef enum logic [1:0] {ADD, SUB, INC, DEC} cmd_t;

endpackage

// File: rtl/register_types.sv
// Microcode address type shared across the address datapath.
package register_types;

  localparam int unsigned ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/seq_types.sv
// Sequencer op, state and fault encodings for useq_ctrl.
package seq_types;

  typedef enum logic [2:0] {NEXT, JMP, JZ, CALL, RET, HALT, LDCNT, LOOP} op_t;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

  typedef enum logic [2:0] {NONE, OVF, UNF, WRAP, ILL} fault_t;

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO. Pointer is reset, contents are not; clear empties it synchronously.
module seq_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]    sp_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_idx;
  logic [PtrW-1:0]  rd_idx;
  logic             do_push;
  logic             do_pop;

  assign wr_idx  = sp_q[PtrW-1:0];
  assign rd_idx  = wr_idx - PtrW'(1);
  assign full    = (sp_q == (PtrW + 1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign dout    = mem_q[rd_idx];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (clear) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + (PtrW + 1)'(1);
    end else if (do_pop) begin
      sp_q <= sp_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microcode sequencer: owns the PC, drives addr_alu for PC+1, handles call/return and faults.
// Optional loop counter and LDCNT/LOOP ops are enabled by defining SEQ_LOOP_EN.
module useq_ctrl
  import register_types::*;
  import alu_types::*;
  import seq_types::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  input  addr_t    start_addr,
  input  logic     stall,
  input  op_t      op,
  input  addr_t    target,
  input  logic     cond,
  output cmd_t     alu_cmd,
  output addr_t    alu_x,
  output addr_t    alu_y,
  input  addr_t    alu_z,
  input  logic     alu_zflag,
  output addr_t    pc,
  output logic     running,
  output logic     halted,
  output fault_t   fault
);

  state_t state_q, state_d;
  addr_t  pc_q, pc_d;
  fault_t fault_q, fault_d;

  logic   stk_clear, stk_push, stk_pop, stk_full, stk_empty;
  addr_t  stk_dout;

`ifdef SEQ_LOOP_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

  seq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (stk_clear),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (alu_z),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign alu_cmd = INC;
  assign alu_x   = pc_q;
  assign alu_y   = '0;
  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign halted  = (state_q == HALTED);
  assign fault   = fault_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
`ifdef SEQ_LOOP_EN
    cnt_d     = cnt_q;
`endif
    if (start) begin
      state_d   = RUN;
      pc_d      = start_addr;
      fault_d   = NONE;
      stk_clear = 1'b1;
`ifdef SEQ_LOOP_EN
      cnt_d     = '0;
`endif
    end else if (state_q == RUN && !stall) begin
      unique case (op)
        NEXT: begin
          if (alu_zflag) begin
            state_d = FAULT;
            fault_d = WRAP;
          end else begin
            pc_d = alu_z;
          end
        end
        JMP: pc_d = target;
        JZ: begin
          if (cond) begin
            pc_d = target;
          end else if (alu_zflag) begin
            state_d = FAULT;
            fault_d = WRAP;
          end else begin
            pc_d = alu_z;
          end
        end
        CALL: begin
          if (stk_full) begin
            state_d = FAULT;
            fault_d = OVF;
          end else begin
            stk_push = 1'b1;
            pc_d     = target;
          end
        end
        RET: begin
          if (stk_empty) begin
            state_d = FAULT;
            fault_d = UNF;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_dout;
          end
        end
        HALT: state_d = HALTED;
`ifdef SEQ_LOOP_EN
        LDCNT: begin
          cnt_d = CNT_W'(target);
          if (alu_zflag) begin
            state_d = FAULT;
            fault_d = WRAP;
          end else begin
            pc_d = alu_z;
          end
        end
        LOOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            pc_d  = target;
          end else if (alu_zflag) begin
            state_d = FAULT;
            fault_d = WRAP;
          end else begin
            pc_d = alu_z;
          end
        end
`endif
        default: begin
          state_d = FAULT;
          fault_d = ILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= NONE;
`ifdef SEQ_LOOP_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
`ifdef SEQ_LOOP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Scoreboard bench for useq_ctrl: stimulus queues expected pc/state/fault, monitor compares.
module tb_useq_ctrl;
  import register_types::*;
  import alu_types::*;
  import seq_types::*;

  typedef struct {
    int     id;
    addr_t  pc;
    logic   run;
    logic   halt;
    fault_t flt;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n, start, stall, cond;
  addr_t  start_addr, target;
  op_t    op;
  cmd_t   alu_cmd;
  addr_t  alu_x, alu_y, alu_z;
  logic   alu_zflag;
  addr_t  pc;
  logic   running, halted;
  fault_t fault;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   next_id = 0;

  always #5 clk = ~clk;

  // Stand-in for the external addr_alu.
  always_comb begin
    alu_z     = alu_x + alu_y + ((alu_cmd == INC) ? 8'd1 : 8'd0);
    alu_zflag = (alu_z == '0);
  end

  useq_ctrl #(
    .STACK_DEPTH (4),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .op         (op),
    .target     (target),
    .cond       (cond),
    .alu_cmd    (alu_cmd),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_z      (alu_z),
    .alu_zflag  (alu_zflag),
    .pc         (pc),
    .running    (running),
    .halted     (halted),
    .fault      (fault)
  );

  task automatic cmp(input exp_t e);
    n_vec++;
    if (pc !== e.pc || running !== e.run || halted !== e.halt || fault !== e.flt) begin
      n_err++;
      $display("FAIL vec%0d: got pc=%h run=%b halt=%b fault=%0d, want pc=%h run=%b halt=%b fault=%0d",
               e.id, pc, running, halted, fault, e.pc, e.run, e.halt, e.flt);
    end
  endtask

  function automatic exp_t mk(input addr_t p, input logic r, input logic h, input fault_t f);
    exp_t e;
    e.id = 0; e.pc = p; e.run = r; e.halt = h; e.flt = f;
    return e;
  endfunction

  task automatic push_exp(input exp_t e);
    e.id = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic go(input addr_t a);
    @(negedge clk);
    start = 1'b1; start_addr = a; stall = 1'b0;
    push_exp(mk(a, 1'b1, 1'b0, NONE));
  endtask

  task automatic step(input op_t o, input addr_t t, input logic c, input logic s,
                      input addr_t p, input logic r, input logic h, input fault_t f);
    @(negedge clk);
    start = 1'b0; op = o; target = t; cond = c; stall = s;
    push_exp(mk(p, r, h, f));
  endtask

  // Monitor: one expectation per clock, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) cmp(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0;
    op = NEXT; target = '0; cond = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    e = mk(8'h00, 1'b0, 1'b0, NONE); e.id = -1; cmp(e);
    @(negedge clk) rst_n = 1'b1;

    // Straight-line execution.
    go(8'h10);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, NONE);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, NONE);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'h13, 1'b1, 1'b0, NONE);

    // Conditional branch with stall.
    step(JZ, 8'h40, 1'b0, 1'b0, 8'h14, 1'b1, 1'b0, NONE);
    step(JZ, 8'h40, 1'b1, 1'b1, 8'h14, 1'b1, 1'b0, NONE);
    step(JZ, 8'h40, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, NONE);

    // Call and return.
    go(8'h20);
    step(CALL, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, NONE);
    step(RET,  8'h00, 1'b0, 1'b0, 8'h21, 1'b1, 1'b0, NONE);

    // Nested returns, then underflow.
    go(8'h30);
    step(CALL, 8'h50, 1'b0, 1'b0, 8'h50, 1'b1, 1'b0, NONE);
    step(CALL, 8'h60, 1'b0, 1'b0, 8'h60, 1'b1, 1'b0, NONE);
    step(RET,  8'h00, 1'b0, 1'b0, 8'h51, 1'b1, 1'b0, NONE);
    step(RET,  8'h00, 1'b0, 1'b0, 8'h31, 1'b1, 1'b0, NONE);
    step(RET,  8'h00, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0, UNF);

    // Overflow on the fifth nested call; fault then holds.
    go(8'h30);
    step(CALL, 8'h50, 1'b0, 1'b0, 8'h50, 1'b1, 1'b0, NONE);
    step(CALL, 8'h60, 1'b0, 1'b0, 8'h60, 1'b1, 1'b0, NONE);
    step(CALL, 8'h70, 1'b0, 1'b0, 8'h70, 1'b1, 1'b0, NONE);
    step(CALL, 8'h78, 1'b0, 1'b0, 8'h78, 1'b1, 1'b0, NONE);
    step(CALL, 8'h90, 1'b0, 1'b0, 8'h78, 1'b0, 1'b0, OVF);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'h78, 1'b0, 1'b0, OVF);

    // PC wrap, then restart clears the fault.
    go(8'hFE);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, NONE);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, WRAP);
    step(JZ,   8'h40, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, WRAP);
    go(8'h00);

    // Jump, halt and hold.
    step(JMP,  8'h05, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, NONE);
    step(HALT, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, NONE);
    for (int i = 0; i < 10; i++) begin
      step(NEXT, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, NONE);
    end

    // Asynchronous reset mid-run takes effect before the next edge.
    go(8'h08);
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, NONE);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    e = mk(8'h00, 1'b0, 1'b0, NONE); e.id = -2; cmp(e);
    @(negedge clk) rst_n = 1'b1;
    step(NEXT, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, NONE);

`ifdef SEQ_LOOP_EN
    go(8'h40);
    step(LDCNT, 8'h03, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, NONE);
    step(LOOP,  8'h41, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, NONE);
    step(LOOP,  8'h41, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, NONE);
    step(LOOP,  8'h41, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, NONE);
    step(LOOP,  8'h41, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, NONE);
    step(LOOP,  8'h41, 1'b0, 1'b0, 8'h43, 1'b1, 1'b0, NONE);
`else
    go(8'h40);
    step(LOOP,  8'h41, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, ILL);
    go(8'h40);
    step(LDCNT, 8'h03, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, ILL);
`endif

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
